// File: rtl/pll_lock_monitor_if.sv
// Control and status bundle for the DCO/FLL lock monitor.
// The housekeeping side is the master; the monitor is the slave.
interface pll_lock_monitor_if #(
  parameter int unsigned DIV_W = 5,
  parameter int unsigned CNT_W = 8
);
  logic             enable;
  logic             osc;
  logic [DIV_W-1:0] div;
  logic [CNT_W-1:0] meas;
  logic             meas_valid;
  logic             err_fast;
  logic             err_slow;
  logic             timeout;
  logic             locked;

  modport master (
    output enable, osc, div,
    input  meas, meas_valid, err_fast, err_slow, timeout, locked
  );

  modport slave (
    input  enable, osc, div,
    output meas, meas_valid, err_fast, err_slow, timeout, locked
  );
endinterface

// File: rtl/pll_lock_monitor.sv
// Lock detector for the generated clock: counts clock cycles per reference period
// and derives fast/slow/timeout errors plus a hysteretic locked flag.
module pll_lock_monitor #(
  parameter int unsigned DIV_W      = 5,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_CNT   = 4,
  parameter int unsigned UNLOCK_CNT = 2
) (
  input logic               clock,
  input logic               reset,
  pll_lock_monitor_if.slave bus
);
  localparam int unsigned EW  = CNT_W + 1;
  localparam int unsigned HMX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
  localparam int unsigned HW  = $clog2(HMX + 1);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, LOCKED} state_t;

  state_t           state;
  logic             s1, s2, s3;
  logic [DIV_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;
  logic [HW-1:0]    good_cnt;
  logic [HW-1:0]    bad_cnt;

  logic          det, div_chg, cnt_sat, timeout_hit;
  logic          is_fast, is_slow, is_good;
  logic [EW-1:0] meas_e, div_e, tol_e;
  logic [HW-1:0] good_inc, bad_inc;

  // Measurement classification, done one bit wider so div-TOL cannot wrap
  always_comb begin
    det         = s2 & ~s3;
    div_chg     = (bus.div != div_q);
    cnt_sat     = &cnt;
    timeout_hit = (state != IDLE) && cnt_sat && !det && !((state != ARM) && div_chg);
    meas_e      = EW'(cnt);
    div_e       = EW'(div_q);
    tol_e       = EW'(TOL);
    is_fast     = meas_e > (div_e + tol_e);
    is_slow     = (meas_e + tol_e) < div_e;
    is_good     = !is_fast && !is_slow && (div_q != '0);
    good_inc    = (good_cnt >= HW'(LOCK_CNT))   ? good_cnt : good_cnt + HW'(1);
    bad_inc     = (bad_cnt  >= HW'(UNLOCK_CNT)) ? bad_cnt  : bad_cnt  + HW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= IDLE;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      div_q          <= '0;
      cnt            <= '0;
      good_cnt       <= '0;
      bad_cnt        <= '0;
      bus.meas       <= '0;
      bus.meas_valid <= 1'b0;
      bus.err_fast   <= 1'b0;
      bus.err_slow   <= 1'b0;
      bus.timeout    <= 1'b0;
      bus.locked     <= 1'b0;
    end else begin
      s1             <= bus.osc;
      s2             <= s1;
      s3             <= s2;
      div_q          <= bus.div;
      bus.meas_valid <= 1'b0;
      bus.err_fast   <= 1'b0;
      bus.err_slow   <= 1'b0;
      bus.timeout    <= 1'b0;

      if (!bus.enable) begin
        state      <= IDLE;
        cnt        <= '0;
        good_cnt   <= '0;
        bad_cnt    <= '0;
        bus.meas   <= '0;
        bus.locked <= 1'b0;
      end else if (timeout_hit) begin
        // Missing reference edge: report a saturated, bad measurement and re-arm
        bus.timeout    <= 1'b1;
        bus.meas       <= '1;
        bus.meas_valid <= 1'b1;
        bus.err_fast   <= 1'b1;
        good_cnt       <= '0;
        bad_cnt        <= bad_inc;
        if (bad_inc >= HW'(UNLOCK_CNT)) bus.locked <= 1'b0;
        cnt            <= CNT_W'(1);
        state          <= ARM;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= ARM;
          end
          ARM: begin
            if (det) begin
              cnt   <= CNT_W'(1);
              state <= bus.locked ? LOCKED : MEAS;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            if (div_chg) begin
              cnt        <= '0;
              good_cnt   <= '0;
              bad_cnt    <= '0;
              bus.locked <= 1'b0;
              state      <= ARM;
            end else if (det) begin
              bus.meas       <= cnt;
              bus.meas_valid <= 1'b1;
              bus.err_fast   <= is_fast;
              bus.err_slow   <= is_slow;
              cnt            <= CNT_W'(1);
              if (is_good) begin
                good_cnt <= good_inc;
                bad_cnt  <= '0;
                if (good_inc >= HW'(LOCK_CNT)) begin
                  state      <= LOCKED;
                  bus.locked <= 1'b1;
                end
              end else begin
                bad_cnt  <= bad_inc;
                good_cnt <= '0;
                if (bad_inc >= HW'(UNLOCK_CNT)) begin
                  state      <= MEAS;
                  bus.locked <= 1'b0;
                end
              end
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_pll_lock_monitor.sv
// Scoreboard bench: an event-level reference model predicts every meas_valid
// from the reference edge times it drives; a monitor pops and compares.
module tb_pll_lock_monitor;
  localparam int unsigned DIV_W = 5;
  localparam int unsigned CNT_W = 8;

  logic clock = 1'b0;
  logic reset;
  int   cyc = 0;

  pll_lock_monitor_if #(.DIV_W(DIV_W), .CNT_W(CNT_W)) bus ();

  pll_lock_monitor #(
    .DIV_W(DIV_W), .CNT_W(CNT_W), .TOL(1), .LOCK_CNT(4), .UNLOCK_CNT(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int meas;
    bit fast;
    bit slow;
    bit to;
    bit lk;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Reference model state, in units of reference-edge times
  int ref_t;
  bit ref_valid;
  bit arm_needed;
  int good_m;
  int bad_m;
  bit locked_m;
  int div_m;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_clear();
    good_m     = 0;
    bad_m      = 0;
    locked_m   = 1'b0;
    arm_needed = 1'b1;
    ref_valid  = 1'b0;
  endfunction

  function automatic void note_bad();
    bad_m  = (bad_m < 2) ? bad_m + 1 : 2;
    good_m = 0;
    if (bad_m >= 2) locked_m = 1'b0;
  endfunction

  // A gap longer than 255 cycles yields a timeout every 255 cycles, then a re-arm
  function automatic void model_advance(input int t);
    while (ref_valid && (t - ref_t > 255)) begin
      note_bad();
      q.push_back('{meas: 255, fast: 1'b1, slow: 1'b0, to: 1'b1, lk: locked_m});
      ref_t      = ref_t + 255;
      arm_needed = 1'b1;
    end
  endfunction

  function automatic void model_edge(input int t);
    int d;
    bit good;
    model_advance(t);
    if (arm_needed) begin
      ref_t      = t;
      ref_valid  = 1'b1;
      arm_needed = 1'b0;
    end else begin
      d     = t - ref_t;
      ref_t = t;
      good  = (div_m != 0) && (d >= div_m - 1) && (d <= div_m + 1);
      if (good) begin
        good_m = (good_m < 4) ? good_m + 1 : 4;
        bad_m  = 0;
        if (good_m >= 4) locked_m = 1'b1;
      end else begin
        note_bad();
      end
      q.push_back('{meas: d, fast: (d > div_m + 1), slow: (d + 1 < div_m), to: 1'b0, lk: locked_m});
    end
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic period(input int p);
    bus.osc = 1'b1;
    model_edge(cyc);
    repeat (p / 2) tick();
    bus.osc = 1'b0;
    repeat (p - p / 2) tick();
  endtask

  task automatic periods(input int p, input int n);
    for (int i = 0; i < n; i++) period(p);
  endtask

  task automatic hold_low(input int n);
    bus.osc = 1'b0;
    model_advance(cyc + n);
    repeat (n) tick();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_meas"},       int'(bus.meas), 0);
    check({tag, "_meas_valid"}, int'(bus.meas_valid), 0);
    check({tag, "_err_fast"},   int'(bus.err_fast), 0);
    check({tag, "_err_slow"},   int'(bus.err_slow), 0);
    check({tag, "_timeout"},    int'(bus.timeout), 0);
    check({tag, "_locked"},     int'(bus.locked), 0);
  endtask

  task automatic div_change(input int nd);
    bus.div = DIV_W'(nd);
    div_m   = nd;
    model_clear();
    tick();
    @(negedge clock);
    check("divchg_locked", int'(bus.locked), 0);
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    @(negedge clock);
    check_quiet("reset");
    repeat (3) tick();
  endtask

  task automatic drop_enable();
    bus.enable = 1'b0;
    tick();
    model_clear();
    @(negedge clock);
    check_quiet("disable");
    tick();
    bus.enable = 1'b1;
    repeat (3) tick();
  endtask

  // Monitor: every meas_valid must match the next predicted measurement
  always @(negedge clock) begin
    if (bus.meas_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_meas_valid", 1, 0);
      end else begin
        mon_e = q.pop_front();
        check("meas",     int'(bus.meas),     mon_e.meas);
        check("err_fast", int'(bus.err_fast), int'(mon_e.fast));
        check("err_slow", int'(bus.err_slow), int'(mon_e.slow));
        check("timeout",  int'(bus.timeout),  int'(mon_e.to));
        check("locked",   int'(bus.locked),   int'(mon_e.lk));
      end
    end
  end

  initial begin
    int j;
    int p;
    int nd;
    reset      = 1'b1;
    bus.enable = 1'b0;
    bus.osc    = 1'b0;
    bus.div    = DIV_W'(8);
    div_m      = 8;
    model_clear();
    repeat (3) tick();
    @(negedge clock);
    check_quiet("init");
    tick();
    reset      = 1'b0;
    bus.enable = 1'b1;
    repeat (3) tick();

    // Nominal lock, then fast/slow/tolerance band and unlock/relock
    periods(8, 7);
    periods(5, 3);
    periods(8, 6);
    periods(10, 3);
    periods(7, 2);
    periods(6, 2);
    periods(8, 6);

    // Reference stops: two timeouts, the second drops lock
    hold_low(600);
    periods(8, 6);

    // Divider change mid-period, relock at the new ratio
    div_change(9);
    periods(9, 6);

    // Counter boundary: 255 is a real measurement, 256 times out first
    period(255);
    period(256);
    periods(9, 6);

    pulse_reset();
    periods(9, 6);

    drop_enable();
    periods(9, 6);

    // Randomised jitter and divider changes
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 19) == 0 && !arm_needed) begin
        nd = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(3, 20));
        if (nd != div_m) div_change(nd);
      end
      j = int'($urandom_range(0, 7)) - 3;
      if (j < -2 || j > 2) j = 0;
      p = div_m + j;
      if (p < 4) p = 4;
      period(p);
    end

    repeat (10) tick();
    check("queue_drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
